// File: rtl/addsub_pkg.sv
// addsub_pkg: shared definitions for the chunk-serial adder/subtractor.
//   OP_ADD / OP_SUB : encodings of the mode input m
//   state_t         : FSM state encoding (IDLE, RUN, DONE)
//   idx_width()     : width of the chunk index counter (clog2, minimum 1)
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-chunk configuration still needs a 1-bit counter.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: combinational CHUNK-bit ripple adder slice with optional
// B inversion for subtraction.
//   a, b  : CHUNK-bit operand chunks
//   m     : 1 inverts b (subtract); the +1 comes in through cin
//   cin   : carry into bit 0
//   sum   : CHUNK-bit result chunk
//   cout  : carry out of the slice MSB
//   cmsb  : carry into the slice MSB (used for signed overflow)
module addsub_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             m,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK-1:0] bx;
  logic [CHUNK:0]   c;

  assign bx = b ^ {CHUNK{m}};

  always_comb begin
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]  = a[i] ^ bx[i] ^ c[i];
      c[i+1]  = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
  end

  assign cout = c[CHUNK];
  assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/addsub_seq.sv
// addsub_seq: chunk-serial two's-complement adder/subtractor.
// Processes CHUNK bits per clock, LSB chunk first, over WIDTH/CHUNK cycles.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid/in_ready   : operand handshake for a, b, m (m: 0 add, 1 subtract)
//   out_valid/out_ready : result handshake for s, cout, ovf, zero
//   s                   : result modulo 2^WIDTH
//   cout                : carry out of MSB (subtract: 1 = no borrow)
//   ovf                 : signed overflow
//   zero                : final result is zero
//   state               : current FSM state, for debug/observation
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds valid and data until then; ready never depends
// combinationally on valid. One operation is in flight at a time: in_ready is
// low from accept until the result is taken, and the result is held stable
// for as long as out_valid is high.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output state_t           state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  generate
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("addsub_seq: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  logic [WIDTH-1:0] a_q, b_q, s_next;
  logic             m_q, carry;
  logic [IDXW-1:0]  idx;
  int               base;
  logic [CHUNK-1:0] sl_sum;
  logic             sl_cout, sl_cmsb;

  assign base = int'(idx) * CHUNK;

  addsub_slice #(.CHUNK(CHUNK)) u_slice (
    .a    (a_q[base +: CHUNK]),
    .b    (b_q[base +: CHUNK]),
    .m    (m_q),
    .cin  (carry),
    .sum  (sl_sum),
    .cout (sl_cout),
    .cmsb (sl_cmsb)
  );

  // Result with the current chunk merged in; on the last chunk this is the
  // full WIDTH-bit result, which is what zero is computed from.
  always_comb begin
    s_next = s;
    s_next[base +: CHUNK] = sl_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      m_q       <= 1'b0;
      carry     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            m_q      <= m;
            carry    <= (m == OP_SUB);  // the +1 of A + ~B + 1
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          s     <= s_next;
          carry <= sl_cout;
          if (idx == LAST_IDX) begin
            cout      <= sl_cout;
            ovf       <= sl_cmsb ^ sl_cout;
            zero      <= ~|s_next;
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
